// File: rtl/collision_scanner.sv
// collision_scanner: walks the platform table one entry per cycle and reports the
// highest platform the falling doodle lands on (optionally with horizontal screen wrap).
module collision_scanner #(
    parameter int N_PLAT       = 93,
    parameter int X_W          = 11,
    parameter int Y_W          = 10,
    parameter int DOODLE_W     = 80,
    parameter int DOODLE_H     = 80,
    parameter int PLAT_W       = 120,
    parameter int LAND_TOL     = 30,
    parameter int SCREEN_W     = 1024,
    parameter int WRAP_X       = 1,
    parameter int GROUND_RESET = 767,
    localparam int RIW         = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [X_W-1:0] doodle_x_i,
    input  logic [Y_W-1:0] doodle_y_i,
    output logic [RIW-1:0] rd_idx_o,
    input  logic [X_W-1:0] plat_x_i,
    input  logic [Y_W-1:0] plat_y_i,
    input  logic           plat_active_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           hit_o,
    output logic [RIW-1:0] hit_idx_o,
    output logic [Y_W-1:0] ground_y_o,
    output logic [X_W-1:0] ground_x_o
);
    localparam int XW = X_W + 2;
    localparam logic [RIW-1:0] LAST = RIW'(N_PLAT - 1);
    localparam logic [Y_W-1:0] GR = Y_W'(GROUND_RESET);
    localparam logic [Y_W:0] DH = (Y_W + 1)'(DOODLE_H);
    localparam logic [Y_W:0] TOL = (Y_W + 1)'(LAND_TOL);
    localparam logic [XW-1:0] DW = XW'(DOODLE_W);
    localparam logic [XW-1:0] PW = XW'(PLAT_W);
    localparam logic [XW-1:0] SW = XW'(SCREEN_W);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] cur_x_q, cur_x_d;
    logic [Y_W-1:0] cur_y_q, cur_y_d;
    logic [Y_W-1:0] prev_y_q, prev_y_d;
    logic           falling_q, falling_d;
    logic [RIW-1:0] rd_idx_q, rd_idx_d;
    logic           iss_q, iss_d;
    logic           dvld_q, dvld_d;
    logic [RIW-1:0] didx_q, didx_d;
    logic           evld_q, evld_d;
    logic           eq_q, eq_d;
    logic [RIW-1:0] eidx_q, eidx_d;
    logic [X_W-1:0] epx_q, epx_d;
    logic [Y_W-1:0] epy_q, epy_d;
    logic           has_q, has_d;
    logic [RIW-1:0] ci_q, ci_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           hit_q, hit_d;
    logic [RIW-1:0] hit_idx_q, hit_idx_d;
    logic [Y_W-1:0] ground_y_q, ground_y_d;
    logic [X_W-1:0] ground_x_q, ground_x_d;

    logic [Y_W:0]  feet, py1;
    logic [XW-1:0] cxe, pxe, pxw;
    logic          in_band, ov, ovw, x_ok, qual, take, last;

    // Qualification of the entry whose read data is on plat_* this cycle.
    always_comb begin
        feet    = {1'b0, cur_y_q} + DH;
        py1     = {1'b0, plat_y_i};
        in_band = (feet >= py1) && (feet <= py1 + TOL);
        cxe     = XW'(cur_x_q);
        pxe     = XW'(plat_x_i);
        pxw     = pxe + SW;
        ov      = (cxe < pxe + PW) && (pxe < cxe + DW);
        ovw     = (WRAP_X != 0) && (cxe < pxw + PW) && (pxw < cxe + DW);
        x_ok    = (ground_y_q == GR) || ov || ovw;
        qual    = plat_active_i && falling_q && in_band && x_ok;
        take    = evld_q && eq_q && (!has_q || epy_q < cy_q);
        last    = evld_q && (eidx_q == LAST);
    end

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        prev_y_d   = prev_y_q;
        falling_d  = falling_q;
        rd_idx_d   = rd_idx_q;
        iss_d      = iss_q;
        has_d      = has_q;
        ci_d       = ci_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hit_d      = 1'b0;
        hit_idx_d  = hit_idx_q;
        ground_y_d = ground_y_q;
        ground_x_d = ground_x_q;
        dvld_d     = (state_q == SCAN) && iss_q;
        didx_d     = rd_idx_q;
        evld_d     = dvld_q;
        eidx_d     = didx_q;
        eq_d       = dvld_q && qual;
        epx_d      = dvld_q ? plat_x_i : epx_q;
        epy_d      = dvld_q ? plat_y_i : epy_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_x_d   = doodle_x_i;
                    cur_y_d   = doodle_y_i;
                    falling_d = doodle_y_i > prev_y_q;
                    prev_y_d  = doodle_y_i;
                    rd_idx_d  = '0;
                    iss_d     = 1'b1;
                    has_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (iss_q) begin
                    iss_d    = rd_idx_q != LAST;
                    rd_idx_d = (rd_idx_q == LAST) ? rd_idx_q : rd_idx_q + RIW'(1);
                end
                // Strictly smaller plat_y replaces the candidate, so ties keep the lower index.
                if (take) begin
                    has_d = 1'b1;
                    ci_d  = eidx_q;
                    cx_d  = epx_q;
                    cy_d  = epy_q;
                end
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hit_d   = has_d;
                    if (has_d) begin
                        hit_idx_d  = ci_d;
                        ground_y_d = cy_d;
                        ground_x_d = cx_d;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            prev_y_q   <= '0;
            falling_q  <= 1'b0;
            rd_idx_q   <= '0;
            iss_q      <= 1'b0;
            dvld_q     <= 1'b0;
            didx_q     <= '0;
            evld_q     <= 1'b0;
            eq_q       <= 1'b0;
            eidx_q     <= '0;
            epx_q      <= '0;
            epy_q      <= '0;
            has_q      <= 1'b0;
            ci_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            ground_y_q <= GR;
            ground_x_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            prev_y_q   <= prev_y_d;
            falling_q  <= falling_d;
            rd_idx_q   <= rd_idx_d;
            iss_q      <= iss_d;
            dvld_q     <= dvld_d;
            didx_q     <= didx_d;
            evld_q     <= evld_d;
            eq_q       <= eq_d;
            eidx_q     <= eidx_d;
            epx_q      <= epx_d;
            epy_q      <= epy_d;
            has_q      <= has_d;
            ci_q       <= ci_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            ground_y_q <= ground_y_d;
            ground_x_q <= ground_x_d;
        end
    end

    assign rd_idx_o   = rd_idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hit_o      = hit_q;
    assign hit_idx_o  = hit_idx_q;
    assign ground_y_o = ground_y_q;
    assign ground_x_o = ground_x_q;
endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
Parametrised landing detector for the doodle. It is the time-multiplexed successor of the all-parallel platform compare. On each frame `start` it walks the platform table one entry per cycle through a synchronous-read port. It applies vertical-band, horizontal-overlap (optionally screen-wrapped) and falling checks, then picks the highest qualifying platform. It sits between the platform generator/RAM and the doodle physics block, which consumes `ground_y`/`ground_x` and the `done`/`hit` pulse.

Parameters:
N_PLAT, 93, number of platform table entries (>=1)
X_W, 11, x coordinate width
Y_W, 10, y coordinate width (y grows downward)
DOODLE_W, 80, doodle sprite width in px
DOODLE_H, 80, feet offset below doodle_y
PLAT_W, 120, platform width in px
LAND_TOL, 30, vertical landing band depth in px
SCREEN_W, 1024, horizontal wrap period
WRAP_X, 1, 1 = horizontal overlap computed modulo SCREEN_W
GROUND_RESET, 767, ground_y after reset (means "never landed")

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  frame strobe; samples doodle_x/doodle_y; accepted only in IDLE
doodle_x  in  X_W  doodle left edge
doodle_y  in  Y_W  doodle top edge
rd_idx  out  $clog2(N_PLAT) (min 1)  platform table read address
plat_x  in  X_W  platform left edge, valid 1 cycle after rd_idx
plat_y  in  Y_W  platform top surface, valid 1 cycle after rd_idx
plat_active  in  1  platform enable, valid 1 cycle after rd_idx
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse, scan complete
hit  out  1  valid with done: a landing was found
hit_idx  out  $clog2(N_PLAT)  index of the selected platform; held between scans
ground_y  out  Y_W  current ground surface; held
ground_x  out  X_W  current ground platform x; held

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, hit=0, rd_idx=0, hit_idx=0, ground_y=GROUND_RESET, ground_x=0, prev_y=0, best-candidate regs cleared.
  - A reset mid-scan aborts the scan: no done pulse, outputs at reset values.
- FSM states IDLE -> SCAN -> DONE -> IDLE.
- IDLE, start=1:
  - latch cur_x=doodle_x, cur_y=doodle_y;
  - falling = (cur_y > prev_y), unsigned compare; then prev_y <= cur_y;
  - rd_idx <= 0, busy <= 1, enter SCAN.
- SCAN:
  - rd_idx increments each cycle up to N_PLAT-1, then holds.
  - Entry i is evaluated on the cycle after rd_idx=i.
  - After entry N_PLAT-1 is evaluated, go to DONE.
- Latency: done is high exactly N_PLAT+2 cycles after the start sample edge.
- Qualification for entry i (all must hold):
  - plat_active;
  - falling;
  - vertical band: plat_y <= feet <= plat_y + LAND_TOL, with feet = cur_y + DOODLE_H. Both sums use Y_W+1 bits, no truncation.
  - horizontal overlap: cur_x < plat_x + PLAT_W AND plat_x < cur_x + DOODLE_W, in X_W+1 bits.
    - If WRAP_X=1, the test is also evaluated with plat_x + SCREEN_W; either passing suffices.
    - While ground_y == GROUND_RESET, the horizontal test is bypassed (the initial floor catches the doodle anywhere).
- Selection:
  - Among qualifying entries, the smallest plat_y wins.
  - Ties go to the lowest index: replace the candidate only on strictly smaller plat_y.
- DONE (1 cycle): done=1, busy=0.
  - If a candidate exists: hit=1 and ground_y/ground_x/hit_idx <= candidate.
  - Otherwise: hit=0, ground_y/ground_x/hit_idx unchanged.
  - hit is valid only while done=1 and is cleared the following cycle.
- start while busy or in DONE: ignored; prev_y is not updated.
- If not falling, the scan still runs full length and reports hit=0.
- plat_* inputs are sampled only on evaluation cycles; other values are don't-care.

Test Plan:
- Reset: assert rst async mid-cycle -> immediately ground_y=767, busy=0, done=0, rd_idx=0; release, start never given -> done stays 0.
- First landing, defaults: start with y=600, x=900 (falling, since prev_y=0); entry 5 = (x=10, y=680, active), all others inactive; feet=680 -> done exactly 95 cycles after start, hit=1, hit_idx=5, ground_y=680, ground_x=10 (x test bypassed).
- Rising frame: start y=610, then start y=600, entry 5 = (x=200, y=680) -> second scan hit=0, ground held at previous values.
- Priority: start y=590 then y=600 (feet=680); entry 3 y=670, entry 7 y=660, entry 2 and 9 both y=655, all x=200, doodle x=200 -> hit_idx=2, ground_y=655.
- Wrap: after a landing (ground_y != 767), doodle x=1000, y rising-to-falling 590->600; entry 4 = (x=10, y=660) -> WRAP_X=1: hit, ground_x=10; WRAP_X=0: hit=0.
- Busy/abort: pulse start again at cycle 20 of a scan -> ignored, done still at cycle 95; assert rst at cycle 40 of a new scan -> no done pulse, ground_y=767.
